// File: rtl/ext_unit_pipe_if.sv
// Request/result handshake bundle for ext_unit_pipe.
// master = producer/consumer side, slave = the extender itself.
interface ext_unit_pipe_if #(
    parameter int OUT_W = 32
) ();
    localparam int OW = $clog2(OUT_W / 8);

    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] in_data;
    logic [2:0]       in_mode;
    logic [OW-1:0]    in_off;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_mode, in_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate / load-data extender with a main result register plus a 1-entry skid.
// Optional statistics counters are built when EXT_STATS_EN is defined.
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef EXT_STATS_EN
    input  logic           stat_clr,
    output logic [31:0]    stat_ops,
    output logic [15:0]    stat_err,
`endif
    ext_unit_pipe_if.slave bus
);
    localparam int NL = OUT_W / 8;
    localparam int OW = $clog2(NL);

    generate
        if ((OUT_W % 16) != 0 || IN_W > OUT_W || IN_W < 1) begin : g_bad_params
            $error("ext_unit_pipe: illegal IN_W/OUT_W combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        MODE_ZERO  = 3'd0,
        MODE_SIGN  = 3'd1,
        MODE_UPPER = 3'd2,
        MODE_LB    = 3'd3,
        MODE_LBU   = 3'd4,
        MODE_LH    = 3'd5,
        MODE_LHU   = 3'd6,
        MODE_WORD  = 3'd7
    } mode_e;

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] data;
    } res_t;

    mode_e         mode;
    logic [IN_W-1:0] imm;
    logic [OW-1:0] off_even;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    res_t          ext_res;

    assign mode     = mode_e'(bus.in_mode);
    assign imm      = bus.in_data[IN_W-1:0];
    assign off_even = bus.in_off & ~OW'(1);
    // Lane select: byte lane n lives at bits [8n+7:8n]; a half lane starts at the even byte.
    assign byte_v   = 8'(bus.in_data >> {bus.in_off, 3'b000});
    assign half_v   = 16'(bus.in_data >> {off_even, 3'b000});

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        ext_res = '0;
        case (mode)
            MODE_ZERO:  ext_res.data = OUT_W'(imm);
            MODE_SIGN:  ext_res.data = OUT_W'($signed(imm));
            MODE_UPPER: ext_res.data = OUT_W'(imm) << (OUT_W - IN_W);
            MODE_LB:    ext_res.data = OUT_W'($signed(byte_v));
            MODE_LBU:   ext_res.data = OUT_W'(byte_v);
            MODE_LH: begin
                if (bus.in_off[0]) ext_res.err  = 1'b1;
                else               ext_res.data = OUT_W'($signed(half_v));
            end
            MODE_LHU: begin
                if (bus.in_off[0]) ext_res.err  = 1'b1;
                else               ext_res.data = OUT_W'(half_v);
            end
            MODE_WORD:  ext_res.data = bus.in_data;
        endcase
    end

    logic in_ready_q, in_ready_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    res_t main_q, main_d;
    res_t skid_q, skid_d;
    logic accept;
    logic drain;

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = main_valid_q && bus.out_ready;

    // The skid only fills when main is stalled, so in_ready gating guarantees it is empty on accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = ext_res;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = ext_res;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            in_ready_q   <= in_ready_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_q.data;
    assign bus.out_err   = main_q.err;

`ifdef EXT_STATS_EN
    logic [31:0] ops_q;
    logic [15:0] err_q;

    // Clear has priority over a same-cycle handshake; counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
            err_q <= '0;
        end else if (stat_clr) begin
            ops_q <= '0;
            err_q <= '0;
        end else if (drain) begin
            ops_q <= ops_q + 32'd1;
            if (main_q.err) err_q <= err_q + 16'd1;
        end
    end

    assign stat_ops = ops_q;
    assign stat_err = err_q;
`endif
endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: directed vectors with literal expectations plus
// a queue-based reference model compared against the DUT on every output cycle.
module tb_ext_unit_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   err_cnt = 0;
    logic [32:0] exp_q[$];

    ext_unit_pipe_if #(.OUT_W(OUT_W)) bus ();

`ifdef EXT_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_ops;
    logic [15:0] stat_err;
`endif

    ext_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef EXT_STATS_EN
        .stat_clr (stat_clr),
        .stat_ops (stat_ops),
        .stat_err (stat_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: arithmetic on unsigned values, signed results formed by subtracting 2^n.
    function automatic logic [32:0] model(input logic [2:0] mode, input logic [31:0] d,
                                          input logic [1:0] off);
        logic [31:0] imm, b, h, r;
        logic        e;
        imm = d & 32'h0000_FFFF;
        b   = (d >> (8 * int'(off))) & 32'h0000_00FF;
        h   = (d >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
        e   = 1'b0;
        r   = 32'd0;
        case (mode)
            3'd0: r = imm;
            3'd1: r = (imm >= 32'h8000) ? imm - 32'h1_0000 : imm;
            3'd2: r = imm * 32'h1_0000;
            3'd3: r = (b >= 32'd128) ? b - 32'd256 : b;
            3'd4: r = b;
            3'd5: if ((int'(off) % 2) != 0) e = 1'b1;
                  else r = (h >= 32'h8000) ? h - 32'h1_0000 : h;
            3'd6: if ((int'(off) % 2) != 0) e = 1'b1;
                  else r = h;
            default: r = d;
        endcase
        return {e, r};
    endfunction

    // Compare process: outputs checked against the model queue every cycle, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hs_cnt  = 0;
            err_cnt = 0;
        end else begin
            if (bus.out_valid || exp_q.size() != 0) begin
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                if (bus.out_valid && exp_q.size() != 0) begin
                    check("out_data", bus.out_data, exp_q[0][31:0]);
                    check("out_err", 32'(bus.out_err), 32'(exp_q[0][32]));
                    if (bus.out_ready) begin
                        if (exp_q[0][32]) err_cnt++;
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_mode, bus.in_data, bus.in_off));
        end
    end

    task automatic send(input logic [2:0] mode, input logic [31:0] d, input logic [1:0] off,
                        output int cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = d;
        bus.in_off   = off;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_single(input string name, input logic [2:0] mode, input logic [31:0] d,
                              input logic [1:0] off, input logic [31:0] exp_d, input logic exp_e);
        logic [32:0] m;
        int          cyc;
        bit          seen;
        m = model(mode, d, off);
        check({name, "_model_data"}, m[31:0], exp_d);
        check({name, "_model_err"}, 32'(m[32]), 32'(exp_e));
        bus.out_ready = 1'b1;
        send(mode, d, off, cyc);
        idle();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_valid"}, 32'(seen), 32'd1);
        check({name, "_data"}, bus.out_data, exp_d);
        check({name, "_err"}, 32'(bus.out_err), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int total;
        int start_hs;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.in_off    = '0;
        bus.out_ready = 1'b0;
`ifdef EXT_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single operations, one per mode family, including the odd-halfword error case.
        run_single("sign_8001",  3'd1, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0);
        run_single("zero_8001",  3'd0, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0);
        run_single("upper_1234", 3'd2, 32'h0000_1234, 2'd0, 32'h1234_0000, 1'b0);
        run_single("upper_hi",   3'd2, 32'hFFFF_1234, 2'd3, 32'h1234_0000, 1'b0);
        run_single("sign_7fff",  3'd1, 32'hABCD_7FFF, 2'd1, 32'h0000_7FFF, 1'b0);
        run_single("lb_off3",    3'd3, 32'h80AA_BBCC, 2'd3, 32'hFFFF_FF80, 1'b0);
        run_single("lbu_off3",   3'd4, 32'h80AA_BBCC, 2'd3, 32'h0000_0080, 1'b0);
        run_single("lb_off0",    3'd3, 32'h80AA_BBCC, 2'd0, 32'hFFFF_FFCC, 1'b0);
        run_single("lbu_off1",   3'd4, 32'h80AA_BBCC, 2'd1, 32'h0000_00BB, 1'b0);
        run_single("lhu_off2",   3'd6, 32'h80AA_BBCC, 2'd2, 32'h0000_80AA, 1'b0);
        run_single("lh_off2",    3'd5, 32'h80AA_BBCC, 2'd2, 32'hFFFF_80AA, 1'b0);
        run_single("lh_off1",    3'd5, 32'h80AA_BBCC, 2'd1, 32'h0000_0000, 1'b1);
        run_single("lhu_off3",   3'd6, 32'h80AA_BBCC, 2'd3, 32'h0000_0000, 1'b1);
        run_single("lh_off0",    3'd5, 32'h0000_7FFF, 2'd0, 32'h0000_7FFF, 1'b0);
        run_single("word_off3",  3'd7, 32'h80AA_BBCC, 2'd3, 32'h80AA_BBCC, 1'b0);

        // Backpressure: A held in main, B in skid, C blocked upstream, then in-order release.
        bus.out_ready = 1'b0;
        send(3'd1, 32'h0000_8001, 2'd0, cyc);
        send(3'd7, 32'hDEAD_BEEF, 2'd0, cyc);
        fork
            begin
                send(3'd4, 32'h0000_3400, 2'd1, cyc);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_data", bus.out_data, 32'hFFFF_8001);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(negedge clk);
                check("bp_rel_a_valid", 32'(bus.out_valid), 32'd1);
                check("bp_rel_a", bus.out_data, 32'hFFFF_8001);
                @(negedge clk);
                check("bp_rel_b_valid", 32'(bus.out_valid), 32'd1);
                check("bp_rel_b", bus.out_data, 32'hDEAD_BEEF);
                @(negedge clk);
                check("bp_rel_c_valid", 32'(bus.out_valid), 32'd1);
                check("bp_rel_c", bus.out_data, 32'h0000_0034);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back random stream: every request must be accepted on its first cycle.
        bus.out_ready = 1'b1;
        start_hs = hs_cnt;
        total = 0;
        for (int i = 0; i < 100; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)), cyc);
            total += cyc;
        end
        idle();
        check("stream_cycles", 32'(total), 32'd100);
        repeat (2) @(posedge clk);
        #1;
        check("stream_handshakes", 32'(hs_cnt - start_hs), 32'd100);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

`ifdef EXT_STATS_EN
        check("stat_ops", stat_ops, 32'(hs_cnt));
        check("stat_err", 32'(stat_err), 32'(err_cnt));
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        check("stat_clr_ops", stat_ops, 32'd0);
        check("stat_clr_err", 32'(stat_err), 32'd0);
`endif

        // Reset while main and skid are both occupied.
        bus.out_ready = 1'b0;
        send(3'd1, 32'h0000_8001, 2'd0, cyc);
        send(3'd7, 32'h1111_2222, 2'd0, cyc);
        idle();
        check("mid_pre_in_ready", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_err", 32'(bus.out_err), 32'd0);
`ifdef EXT_STATS_EN
        check("mid_rst_stat_ops", stat_ops, 32'd0);
        check("mid_rst_stat_err", 32'(stat_err), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_discard", 32'(bus.out_valid), 32'd0);

        run_single("after_rst_lbu", 3'd4, 32'h1234_5678, 2'd2, 32'h0000_0034, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
